tx_dispatcher: RTL and testbench
================================

# tx_dispatcher

Host-to-peripheral counterpart of the RX arbiter. It pops packets from the host receive FIFO, decodes a one-word header carrying the destination peripheral and payload length, and steers the payload words into the addressed one of eight peripheral TX FIFOs. It honours per-FIFO backpressure and discards packets addressed to disabled peripherals.

## Interface
- PERIPH_ENABLE, 8'hFF: bit n = 1 means peripheral n exists; packets to a disabled n are dropped.
- DATA_WIDTH, 32: word width; must be ≥ 32.

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- host_rx_empty  in  1  host RX FIFO empty (first-word-fall-through)
- host_rx_data  in  DATA_WIDTH  head word of host RX FIFO, valid when !host_rx_empty
- host_rx_rd  out  1  pop host RX FIFO this cycle
- tx_fifo_full  in  8  full flag of each peripheral TX FIFO
- tx_fifo_wr  out  8  one-hot write strobe into peripheral TX FIFO n
- tx_fifo_data  out  DATA_WIDTH  write data, shared by all eight TX FIFOs
- busy  out  1  packet in progress (state ≠ IDLE)
- dest  out  3  destination of current/last packet
- drop_pulse  out  1  one-cycle pulse when a header to a disabled peripheral is accepted

## Operation
- Header word: [31:29] destination n, [28:8] reserved (ignored), [7:0] payload length L (0–255 words).
- States: IDLE, PAYLOAD, DROP.
- IDLE: if !host_rx_empty, assert host_rx_rd (header pop), register dest ← [31:29], count ← L.
  - L = 0 → stay IDLE (header-only packet, no writes, no error).
  - PERIPH_ENABLE[n] = 0 and L > 0 → DROP; drop_pulse = 1 in the following cycle.
  - PERIPH_ENABLE[n] = 0 and L = 0 → stay IDLE; drop_pulse still pulses.
  - otherwise → PAYLOAD.
- PAYLOAD: pop = !host_rx_empty && !tx_fifo_full[dest]; host_rx_rd = pop; tx_fifo_wr[dest] = pop, all other bits 0; count decrements on pop; pop with count == 1 → IDLE.
- DROP: host_rx_rd = !host_rx_empty; tx_fifo_wr = 0; count decrements on pop; count == 1 with pop → IDLE.
- tx_fifo_data = host_rx_data combinationally at all times; it is only meaningful when a wr bit is set.
- count is 8 bits and never wraps: it is loaded with L ≥ 1 only and exits the state on reaching 1.
- tx_fifo_full on a non-destination FIFO has no effect. Empty and full together → no pop, no write, state held.

## Timing
- Reset values: host_rx_rd 0, tx_fifo_wr 8'h00, busy 0, dest 3'd0, drop_pulse 0, state IDLE, count 0. tx_fifo_data follows host_rx_data.
- Header costs exactly one cycle. Payload then moves at one word per cycle with zero added latency: the write occurs in the same cycle as the pop.
- A packet of L words with no stalls occupies L+1 cycles. The next header can be popped the cycle after the last payload pop; there are no idle bubbles between packets.
- Outputs host_rx_rd and tx_fifo_wr are combinational from state, count, host_rx_empty and tx_fifo_full. State, count, dest and drop_pulse are registered.
- Reset asserted mid-packet returns to IDLE immediately (asynchronous). Remaining payload words in the host FIFO will then be parsed as headers; resynchronising is the host's responsibility.

## Test plan
- Basic: header 32'h4000_0003 followed by 3 words, all FIFOs empty/not full → tx_fifo_wr = 8'h04 for 3 consecutive cycles with data in order. busy high for 3 cycles after the header cycle. Total 4 cycles.
- Backpressure: dest 5, L = 4, tx_fifo_full[5] high for 2 cycles mid-payload → host_rx_rd and tx_fifo_wr[5] low during those cycles, no word lost or duplicated. Toggling tx_fifo_full[2] has no effect.
- Drop: PERIPH_ENABLE = 8'h7F, header 32'hE000_0002 plus 2 words → drop_pulse for 1 cycle, 2 words popped, tx_fifo_wr stays 0, then back to IDLE.
- Boundaries: L = 0 header → one pop, no writes, busy stays 0. Header with L = 255 to dest 0 → exactly 255 writes, count reaches IDLE without wrap. Back-to-back packets to dests 1 then 6 → no gap cycles.
- Host underflow: host_rx_empty toggles every other cycle during payload → writes only on non-empty cycles, packet completes.
- Reset mid-packet: rst asserted after 2 of 5 payload words → all outputs at reset values within the same cycle. After release, the state is IDLE and the next non-empty word is treated as a header.

Source files
------------

// File: rtl/tx_dispatcher.sv
// -----------------------------------------------------------------------------
// tx_dispatcher
// Pops packets from the host receive FIFO (first-word-fall-through), decodes a
// one-word header {dest[31:29], reserved[28:8], length[7:0]} and steers the
// following payload words into one of eight peripheral TX FIFOs. Per-FIFO
// backpressure is honoured. Packets addressed to disabled peripherals are
// drained from the host FIFO and discarded.
//
// Parameters
//   PERIPH_ENABLE  bit n = 1 : peripheral n exists
//   DATA_WIDTH     word width (>= 32)
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   host_rx_empty  host RX FIFO empty
//   host_rx_data   head word of host RX FIFO
//   host_rx_rd     pop host RX FIFO this cycle
//   tx_fifo_full   full flag per peripheral TX FIFO
//   tx_fifo_wr     one-hot write strobe per peripheral TX FIFO
//   tx_fifo_data   write data shared by all TX FIFOs
//   busy           packet in progress
//   dest           destination of current/last packet
//   drop_pulse     one-cycle pulse after a header to a disabled peripheral
// -----------------------------------------------------------------------------
module tx_dispatcher #(
  parameter logic [7:0] PERIPH_ENABLE = 8'hFF,
  parameter int         DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_rx_empty,
  input  logic [DATA_WIDTH-1:0] host_rx_data,
  output logic                  host_rx_rd,
  input  logic [7:0]            tx_fifo_full,
  output logic [7:0]            tx_fifo_wr,
  output logic [DATA_WIDTH-1:0] tx_fifo_data,
  output logic                  busy,
  output logic [2:0]            dest,
  output logic                  drop_pulse
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_DROP    = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_count;
  logic [2:0] r_dest;
  logic       r_drop_pulse;

  logic [2:0] w_hdr_dest;
  logic [7:0] w_hdr_len;
  logic       w_pop;
  logic [7:0] w_wr;

  assign w_hdr_dest = host_rx_data[31:29];
  assign w_hdr_len  = host_rx_data[7:0];

  // Pop decision per state; reset is folded in so the pop strobe drops
  // together with the registers when reset is asserted mid-cycle.
  always_comb begin
    w_pop = 1'b0;
    if (rst) begin
      w_pop = 1'b0;
    end else begin
      case (r_state)
        S_IDLE:    w_pop = !host_rx_empty;
        S_PAYLOAD: w_pop = !host_rx_empty && !tx_fifo_full[r_dest];
        S_DROP:    w_pop = !host_rx_empty;
        default:   w_pop = 1'b0;
      endcase
    end
  end

  // Write strobe: only payload pops write, and only into the destination FIFO.
  always_comb begin
    w_wr = 8'h00;
    if ((r_state == S_PAYLOAD) && w_pop) begin
      w_wr = 8'h01 << r_dest;
    end else begin
      w_wr = 8'h00;
    end
  end

  // Packet state machine: header decode, payload countdown, drop handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= 8'd0;
      r_dest       <= 3'd0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_dest  <= w_hdr_dest;
            r_count <= w_hdr_len;
            if (!PERIPH_ENABLE[w_hdr_dest]) begin
              // Pulse even for zero-length headers so the host sees every drop.
              r_drop_pulse <= 1'b1;
              if (w_hdr_len != 8'd0) begin
                r_state <= S_DROP;
              end
            end else if (w_hdr_len != 8'd0) begin
              r_state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD, S_DROP: begin
          if (w_pop) begin
            // Count is loaded with >= 1 and the state exits at 1: it never wraps.
            r_count <= r_count - 8'd1;
            if (r_count == 8'd1) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign host_rx_rd   = w_pop;
  assign tx_fifo_wr   = w_wr;
  assign tx_fifo_data = host_rx_data;
  assign busy         = (r_state != S_IDLE);
  assign dest         = r_dest;
  assign drop_pulse   = r_drop_pulse;

endmodule

// File: tb/tb_tx_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_tx_dispatcher
// Self-checking bench for tx_dispatcher. The host FIFO is a queue of words
// built packet by packet; each word is tagged with its role in the stream
// (header, payload, discarded payload) and its packet destination. Expected
// pops, writes and status outputs are derived each cycle from that tagging.
// -----------------------------------------------------------------------------
module tb_tx_dispatcher;

  localparam logic [7:0] EN = 8'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_rx_empty;
  logic [31:0] host_rx_data;
  logic        host_rx_rd;
  logic [7:0]  tx_fifo_full;
  logic [7:0]  tx_fifo_wr;
  logic [31:0] tx_fifo_data;
  logic        busy;
  logic [2:0]  dest;
  logic        drop_pulse;

  tx_dispatcher #(.PERIPH_ENABLE(EN), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .host_rx_empty(host_rx_empty), .host_rx_data(host_rx_data),
    .host_rx_rd(host_rx_rd),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_wr(tx_fifo_wr),
    .tx_fifo_data(tx_fifo_data),
    .busy(busy), .dest(dest), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  // Stream model: word, role (0 header, 1 payload, 2 discarded), packet dest
  logic [31:0] wq[$];
  logic [1:0]  role_q[$];
  logic [2:0]  pd_q[$];
  int          idx;
  logic [2:0]  exp_dest;
  logic        exp_drop;
  int          wr_cnt[8];
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic push_packet(input logic [2:0] d, input int len);
    wq.push_back({d, 21'($urandom), 8'(len)});
    role_q.push_back(2'd0);
    pd_q.push_back(d);
    for (int i = 0; i < len; i++) begin
      wq.push_back($urandom);
      role_q.push_back(EN[d] ? 2'd1 : 2'd2);
      pd_q.push_back(d);
    end
  endtask

  task automatic cycle(input logic [7:0] full_v, input bit empty_v);
    logic       have;
    logic       pop;
    logic [1:0] r;
    logic [2:0] d;
    logic [7:0] ewr;
    @(negedge clk);
    have          = (idx < wq.size());
    host_rx_empty = empty_v || !have;
    host_rx_data  = have ? wq[idx] : $urandom;
    tx_fifo_full  = full_v;
    r = have ? role_q[idx] : 2'd0;
    d = have ? pd_q[idx] : 3'd0;
    #2;
    pop = !host_rx_empty && !((r == 2'd1) && full_v[d]);
    ewr = (pop && (r == 2'd1)) ? (8'h01 << d) : 8'h00;
    check("host_rx_rd", host_rx_rd, pop);
    check("tx_fifo_wr", tx_fifo_wr, ewr);
    if (ewr != 8'h00) check("tx_fifo_data", tx_fifo_data, wq[idx]);
    check("busy", busy, have && (r != 2'd0));
    check("dest", dest, exp_dest);
    check("drop_pulse", drop_pulse, exp_drop);
    exp_drop = 1'b0;
    if (pop) begin
      if (r == 2'd0) begin
        exp_dest = d;
        exp_drop = !EN[d];
      end
      if (ewr != 8'h00) wr_cnt[d]++;
      idx++;
    end
  endtask

  // empty_mode: 0 never empty, 1 random gaps, 2 empty every other cycle
  task automatic drain(input int full_pct, input int empty_mode, input int budget);
    int   cnt;
    bit   e;
    logic [7:0] f;
    cnt = 0;
    while (cnt < budget && idx < wq.size()) begin
      f = ($urandom_range(99) < full_pct) ? 8'($urandom) : 8'h00;
      case (empty_mode)
        1:       e = ($urandom_range(3) == 0);
        2:       e = (cnt % 2 == 1);
        default: e = 1'b0;
      endcase
      cycle(f, e);
      cnt++;
    end
    if (idx < wq.size()) check("drain_timeout", idx, wq.size());
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idx      = 0;
    exp_dest = 3'd0;
    exp_drop = 1'b0;
    for (int i = 0; i < 8; i++) wr_cnt[i] = 0;
    rst           = 1'b1;
    host_rx_empty = 1'b1;
    host_rx_data  = 32'h0;
    tx_fifo_full  = 8'h00;
    #2;
    check("reset_rd", host_rx_rd, 1'b0);
    check("reset_wr", tx_fifo_wr, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_dest", dest, 3'd0);
    check("reset_drop", drop_pulse, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Basic: dest 2, three words
    push_packet(3'd2, 3);
    drain(0, 0, 50);
    check("basic_writes", wr_cnt[2], 3);

    // Backpressure on dest 5 for two cycles mid-payload, FIFO 2 toggling
    push_packet(3'd5, 4);
    cycle(8'h00, 1'b0);
    cycle(8'h04, 1'b0);
    cycle(8'h20, 1'b0);
    cycle(8'h24, 1'b0);
    drain(0, 0, 50);
    check("bp_writes", wr_cnt[5], 4);

    // Drop to disabled peripheral 7, with and without payload
    push_packet(3'd7, 2);
    drain(0, 0, 50);
    push_packet(3'd7, 0);
    drain(0, 0, 50);
    check("drop_no_writes", wr_cnt[7], 0);

    // Header-only packet
    push_packet(3'd1, 0);
    drain(0, 0, 50);

    // Longest packet
    wr_cnt[0] = 0;
    push_packet(3'd0, 255);
    drain(0, 0, 400);
    check("long_writes", wr_cnt[0], 255);

    // Back-to-back packets
    push_packet(3'd1, 3);
    push_packet(3'd6, 2);
    drain(0, 0, 50);

    // Host underflow every other cycle
    wr_cnt[4] = 0;
    push_packet(3'd4, 6);
    drain(0, 2, 100);
    check("underflow_writes", wr_cnt[4], 6);

    // Reset after 2 of 5 payload words; leftovers become zero-length headers
    push_packet(3'd3, 5);
    wq[wq.size()-3] = 32'h2000_0000;
    wq[wq.size()-2] = 32'h4000_0000;
    wq[wq.size()-1] = 32'h8000_0000;
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    @(negedge clk);
    host_rx_empty = 1'b0;
    host_rx_data  = wq[idx];
    tx_fifo_full  = 8'h00;
    #1 rst = 1'b1;
    #1;
    check("midrst_rd", host_rx_rd, 1'b0);
    check("midrst_wr", tx_fifo_wr, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_dest", dest, 3'd0);
    check("midrst_drop", drop_pulse, 1'b0);
    @(negedge clk);
    host_rx_empty = 1'b1;
    rst = 1'b0;
    for (int k = idx; k < wq.size(); k++) begin
      role_q[k] = 2'd0;
      pd_q[k]   = wq[k][31:29];
    end
    exp_dest = 3'd0;
    exp_drop = 1'b0;
    drain(0, 0, 50);

    // Randomized traffic with backpressure and host gaps
    for (int p = 0; p < 40; p++) begin
      push_packet(3'($urandom_range(7)), $urandom_range(20));
    end
    drain(30, 1, 5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
